// File: rtl/kbd_cmd_pkg.sv
// Shared constants, parser state type and key decode for the keyboard command scheduler.
package kbd_cmd_pkg;

  localparam logic [2:0] CmdNone     = 3'd0;
  localparam logic [2:0] CmdLeft     = 3'd1;
  localparam logic [2:0] CmdRight    = 3'd2;
  localparam logic [2:0] CmdSoftDrop = 3'd3;
  localparam logic [2:0] CmdRotCw    = 3'd4;
  localparam logic [2:0] CmdHardDrop = 3'd5;
  localparam logic [2:0] CmdPause    = 3'd6;
  localparam logic [2:0] CmdRotCcw   = 3'd7;

  localparam logic [7:0] ScExt   = 8'hE0;
  localparam logic [7:0] ScBrk   = 8'hF0;
  localparam logic [7:0] ScLeft  = 8'h6B;
  localparam logic [7:0] ScRight = 8'h74;
  localparam logic [7:0] ScDown  = 8'h72;
  localparam logic [7:0] ScUp    = 8'h75;
  localparam logic [7:0] ScSpace = 8'h29;
  localparam logic [7:0] ScP     = 8'h4D;
  localparam logic [7:0] ScZ     = 8'h1A;

  localparam int unsigned FifoDepth = 4;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} parse_state_e;

  // Returns CmdNone for any unmapped (ext, scancode) pair.
  function automatic logic [2:0] map_key(input logic ext, input logic [7:0] sc);
    logic [2:0] code;
    code = CmdNone;
    if (ext) begin
      case (sc)
        ScLeft:  code = CmdLeft;
        ScRight: code = CmdRight;
        ScDown:  code = CmdSoftDrop;
        ScUp:    code = CmdRotCw;
        default: code = CmdNone;
      endcase
    end else begin
      case (sc)
        ScSpace: code = CmdHardDrop;
        ScP:     code = CmdPause;
        ScZ:     code = CmdRotCcw;
        default: code = CmdNone;
      endcase
    end
    return code;
  endfunction

  function automatic logic is_repeatable(input logic [2:0] code);
    return (code == CmdLeft) || (code == CmdRight) || (code == CmdSoftDrop);
  endfunction

endpackage

// File: rtl/kbd_cmd_scheduler_fifo.sv
// Four-entry command FIFO; a push alongside a pop is accepted even when full.
module cmd_fifo
  import kbd_cmd_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] wdata,
  output logic [2:0] rdata,
  output logic       full,
  output logic       empty
);

  logic [2:0] mem_q [FifoDepth];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       do_push, do_pop;

  assign empty   = (count_q == 3'd0);
  assign full    = (count_q == 3'(FifoDepth));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? CmdNone : mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/kbd_cmd_scheduler.sv
// PS/2 set-2 scancode parser producing Tetris commands, with typematic suppression,
// delayed auto-shift for movement keys and a small command queue.
module kbd_cmd_scheduler
  import kbd_cmd_pkg::*;
#(
  parameter int unsigned DAS_DELAY  = 8000000,
  parameter int unsigned ARR_PERIOD = 2500000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  input  logic       flush,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [6:0] held_keys,
  output logic       overflow
);

  parse_state_e     state_q, state_d;
  logic [6:0]       held_q, held_d;
  logic             rpt_active_q, rpt_active_d;
  logic [2:0]       rpt_key_q, rpt_key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;

  logic       is_make, is_brk, is_ext;
  logic [2:0] key, key_idx;
  logic       parser_push, rpt_fire, can_push, pop;
  logic       fifo_push, fifo_full, fifo_empty;
  logic [2:0] fifo_wdata;

  always_comb begin
    state_d = state_q;
    is_make = 1'b0;
    is_brk  = 1'b0;
    is_ext  = 1'b0;
    if (ps2_key_pressed) begin
      unique case (state_q)
        StIdle: begin
          if (ps2_key_data == ScExt)      state_d = StExt;
          else if (ps2_key_data == ScBrk) state_d = StBrk;
          else                            is_make = 1'b1;
        end
        StExt: begin
          if (ps2_key_data == ScBrk) begin
            state_d = StExtBrk;
          end else if (ps2_key_data != ScExt) begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = StIdle;
          end
        end
        StBrk: begin
          is_brk  = 1'b1;
          state_d = StIdle;
        end
        StExtBrk: begin
          is_brk  = 1'b1;
          is_ext  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign key         = map_key(is_ext, ps2_key_data);
  assign key_idx     = key - 3'd1;
  assign parser_push = is_make && (key != CmdNone) && !held_q[key_idx];
  assign pop         = cmd_valid & cmd_ready;
  assign can_push    = ~fifo_full | pop;

  always_comb begin
    held_d       = held_q;
    rpt_active_d = rpt_active_q;
    rpt_key_d    = rpt_key_q;
    cnt_d        = cnt_q;
    rpt_fire     = 1'b0;

    // A parser push takes the slot; the counter parks at zero and fires next cycle.
    if (rpt_active_q) begin
      if (cnt_q == '0) begin
        if (!parser_push) begin
          rpt_fire = 1'b1;
          cnt_d    = CNT_W'(ARR_PERIOD - 1);
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (parser_push) begin
      held_d[key_idx] = 1'b1;
      if (is_repeatable(key)) begin
        rpt_active_d = 1'b1;
        rpt_key_d    = key;
        cnt_d        = CNT_W'(DAS_DELAY - 1);
      end
    end else if (is_brk && (key != CmdNone)) begin
      held_d[key_idx] = 1'b0;
      if (rpt_active_q && (rpt_key_q == key)) rpt_active_d = 1'b0;
    end
  end

  assign fifo_push  = (parser_push | rpt_fire) & can_push;
  assign fifo_wdata = parser_push ? key : rpt_key_q;
  assign overflow_d = overflow_q | (parser_push & ~can_push);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      held_q       <= '0;
      rpt_active_q <= 1'b0;
      rpt_key_q    <= CmdNone;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
    end else if (flush) begin
      state_q      <= StIdle;
      held_q       <= '0;
      rpt_active_q <= 1'b0;
      rpt_key_q    <= CmdNone;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      rpt_active_q <= rpt_active_d;
      rpt_key_q    <= rpt_key_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  cmd_fifo u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .flush  (flush),
    .push   (fifo_push),
    .pop    (pop),
    .wdata  (fifo_wdata),
    .rdata  (cmd_code),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign cmd_valid = ~fifo_empty;
  assign held_keys = held_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_kbd_cmd_scheduler.sv
// Scoreboard bench for kbd_cmd_scheduler with shortened auto-repeat timing.
module tb_kbd_cmd_scheduler;

  logic       clock;
  logic       resetn;
  logic       ps2_key_pressed;
  logic [7:0] ps2_key_data;
  logic       flush;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [6:0] held_keys;
  logic       overflow;

  int n_checks;
  int n_fail;

  logic [2:0] exp_q[$];
  logic [2:0] exp_c;
  logic [2:0] obs_code [256];
  int         obs_cyc [256];
  int         obs_wr;
  int         obs_rd;
  int         cyc;

  kbd_cmd_scheduler #(
    .DAS_DELAY  (20),
    .ARR_PERIOD (5),
    .CNT_W      (24)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .flush           (flush),
    .cmd_ready       (cmd_ready),
    .cmd_valid       (cmd_valid),
    .cmd_code        (cmd_code),
    .held_keys       (held_keys),
    .overflow        (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Records every accepted command and the cycle it left the queue.
  initial begin
    obs_wr = 0;
    cyc    = 0;
  end
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (cmd_valid && cmd_ready && obs_wr < 256) begin
      obs_code[obs_wr] = cmd_code;
      obs_cyc[obs_wr]  = cyc;
      obs_wr           = obs_wr + 1;
    end
  end

  // Caller sits just after a rising edge; strobe lasts exactly one cycle.
  task automatic send_byte(input logic [7:0] b);
    ps2_key_pressed = 1'b1;
    ps2_key_data    = b;
    @(posedge clock); #1;
    ps2_key_pressed = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
    n_checks++; if (cmd_code !== 3'd0) begin n_fail++; $display("FAIL reset_code got=%0d exp=0", cmd_code); end
    n_checks++; if (held_keys !== 7'd0) begin n_fail++; $display("FAIL reset_held got=%b exp=0", held_keys); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_make_left;
    cmd_ready = 1'b1;
    send_byte(8'hE0);
    exp_q.push_back(3'd1);
    send_byte(8'h6B);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL left_valid got=%b exp=1", cmd_valid); end
    n_checks++; if (cmd_code !== 3'd1) begin n_fail++; $display("FAIL left_code got=%0d exp=1", cmd_code); end
    n_checks++; if (held_keys !== 7'b0000001) begin n_fail++; $display("FAIL left_held got=%b exp=0000001", held_keys); end
    idle(1);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL left_popped got=%b exp=0", cmd_valid); end
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      exp_c = exp_q.pop_front();
      n_checks++; if (obs_code[obs_rd] !== exp_c) begin n_fail++; $display("FAIL left_sb got=%0d exp=%0d", obs_code[obs_rd], exp_c); end
      obs_rd++;
    end
  endtask

  task automatic test_auto_repeat;
    int base;
    base = obs_wr - 1;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd1);
    for (int i = 0; i < 60 && obs_wr < base + 3; i++) idle(1);
    n_checks++; if (obs_wr < base + 3) begin n_fail++; $display("FAIL rpt_timeout got=%0d exp=%0d", obs_wr - base, 3); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    idle(30);
    n_checks++; if (obs_wr !== base + 3) begin n_fail++; $display("FAIL rpt_stop got=%0d exp=%0d", obs_wr - base, 3); end
    n_checks++; if (held_keys !== 7'd0) begin n_fail++; $display("FAIL rpt_held got=%b exp=0", held_keys); end
    n_checks++; if (obs_cyc[base + 1] - obs_cyc[base] !== 20) begin n_fail++; $display("FAIL rpt_das got=%0d exp=20", obs_cyc[base + 1] - obs_cyc[base]); end
    n_checks++; if (obs_cyc[base + 2] - obs_cyc[base + 1] !== 5) begin n_fail++; $display("FAIL rpt_arr got=%0d exp=5", obs_cyc[base + 2] - obs_cyc[base + 1]); end
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      exp_c = exp_q.pop_front();
      n_checks++; if (obs_code[obs_rd] !== exp_c) begin n_fail++; $display("FAIL rpt_sb got=%0d exp=%0d", obs_code[obs_rd], exp_c); end
      obs_rd++;
    end
  endtask

  task automatic test_typematic;
    int base;
    base = obs_wr;
    exp_q.push_back(3'd1);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hE0);
      send_byte(8'h6B);
    end
    idle(8);
    n_checks++; if (obs_wr !== base + 1) begin n_fail++; $display("FAIL typematic_count got=%0d exp=1", obs_wr - base); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    idle(25);
    n_checks++; if (obs_wr !== base + 1) begin n_fail++; $display("FAIL typematic_norpt got=%0d exp=1", obs_wr - base); end
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      exp_c = exp_q.pop_front();
      n_checks++; if (obs_code[obs_rd] !== exp_c) begin n_fail++; $display("FAIL typematic_sb got=%0d exp=%0d", obs_code[obs_rd], exp_c); end
      obs_rd++;
    end
  endtask

  task automatic test_overflow;
    int base;
    base = obs_wr;
    cmd_ready = 1'b0;
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd4);
    send_byte(8'h29);
    send_byte(8'h1A);
    send_byte(8'h4D);
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'h72);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    n_checks++; if (held_keys !== 7'b1111100) begin n_fail++; $display("FAIL ovf_held got=%b exp=1111100", held_keys); end
    idle(25);
    n_checks++; if (cmd_code !== 3'd5) begin n_fail++; $display("FAIL ovf_head got=%0d exp=5", cmd_code); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h72);
    cmd_ready = 1'b1;
    idle(8);
    n_checks++; if (obs_wr !== base + 4) begin n_fail++; $display("FAIL ovf_count got=%0d exp=4", obs_wr - base); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      exp_c = exp_q.pop_front();
      n_checks++; if (obs_code[obs_rd] !== exp_c) begin n_fail++; $display("FAIL ovf_sb got=%0d exp=%0d", obs_code[obs_rd], exp_c); end
      obs_rd++;
    end
    send_byte(8'hF0); send_byte(8'h29);
    send_byte(8'hF0); send_byte(8'h1A);
    send_byte(8'hF0); send_byte(8'h4D);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    idle(2);
    n_checks++; if (held_keys !== 7'd0) begin n_fail++; $display("FAIL ovf_release got=%b exp=0", held_keys); end
    n_checks++; if (obs_wr !== base + 4) begin n_fail++; $display("FAIL ovf_release_push got=%0d exp=4", obs_wr - base); end
  endtask

  task automatic test_break_unheld;
    int base;
    base = obs_wr;
    send_byte(8'hF0);
    send_byte(8'h29);
    idle(3);
    n_checks++; if (held_keys !== 7'd0) begin n_fail++; $display("FAIL brk_held got=%b exp=0", held_keys); end
    n_checks++; if (obs_wr !== base) begin n_fail++; $display("FAIL brk_push got=%0d exp=0", obs_wr - base); end
    exp_q.push_back(3'd5);
    send_byte(8'h29);
    n_checks++; if (cmd_code !== 3'd5) begin n_fail++; $display("FAIL brk_make_code got=%0d exp=5", cmd_code); end
    n_checks++; if (held_keys !== 7'b0010000) begin n_fail++; $display("FAIL brk_make_held got=%b exp=0010000", held_keys); end
    idle(2);
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      exp_c = exp_q.pop_front();
      n_checks++; if (obs_code[obs_rd] !== exp_c) begin n_fail++; $display("FAIL brk_sb got=%0d exp=%0d", obs_code[obs_rd], exp_c); end
      obs_rd++;
    end
    send_byte(8'hF0);
    send_byte(8'h29);
  endtask

  task automatic test_flush_reset;
    int base;
    base = obs_wr;
    send_byte(8'hE0);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_ovf got=%b exp=0", overflow); end
    send_byte(8'h6B);
    idle(3);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", cmd_valid); end
    n_checks++; if (obs_wr !== base) begin n_fail++; $display("FAIL flush_push got=%0d exp=0", obs_wr - base); end
    // Strobe coinciding with flush must vanish.
    flush = 1'b1;
    send_byte(8'h29);
    flush = 1'b0;
    idle(2);
    n_checks++; if (held_keys !== 7'd0) begin n_fail++; $display("FAIL flush_strobe got=%b exp=0", held_keys); end
    // Reset after E0 leaves the following 6B non-extended.
    send_byte(8'hE0);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    send_byte(8'h6B);
    idle(3);
    n_checks++; if (obs_wr !== base) begin n_fail++; $display("FAIL rst_midseq got=%0d exp=0", obs_wr - base); end
    exp_q.push_back(3'd2);
    send_byte(8'hE0);
    send_byte(8'h74);
    idle(2);
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      exp_c = exp_q.pop_front();
      n_checks++; if (obs_code[obs_rd] !== exp_c) begin n_fail++; $display("FAIL right_sb got=%0d exp=%0d", obs_code[obs_rd], exp_c); end
      obs_rd++;
    end
    cmd_ready = 1'b0;
    send_byte(8'h29);
    n_checks++; if (held_keys !== 7'b0010010) begin n_fail++; $display("FAIL pre_rst_held got=%b exp=0010010", held_keys); end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got=%b exp=0", cmd_valid); end
    n_checks++; if (cmd_code !== 3'd0) begin n_fail++; $display("FAIL async_code got=%0d exp=0", cmd_code); end
    n_checks++; if (held_keys !== 7'd0) begin n_fail++; $display("FAIL async_held got=%b exp=0", held_keys); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL async_ovf got=%b exp=0", overflow); end
    idle(1);
    resetn = 1'b1;
    cmd_ready = 1'b1;
    base = obs_wr;
    idle(30);
    n_checks++; if (obs_wr !== base) begin n_fail++; $display("FAIL post_rst_rpt got=%0d exp=0", obs_wr - base); end
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    obs_rd          = 0;
    resetn          = 1'b0;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
    flush           = 1'b0;
    cmd_ready       = 1'b0;
    idle(3);
    test_reset();
    resetn = 1'b1;
    idle(2);
    test_make_left();
    test_auto_repeat();
    test_typematic();
    test_overflow();
    test_break_unheld();
    test_flush_reset();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    n_checks++; if (obs_rd !== obs_wr) begin n_fail++; $display("FAIL sb_extra got=%0d exp=%0d", obs_wr, obs_rd); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kbd_cmd_scheduler.md
Name: kbd_cmd_scheduler

Overview:
- Sits between PS2_Interface and the processor/game logic.
- Parses raw PS/2 set-2 scancode bytes (E0/F0 prefixes) into Tetris game commands and suppresses keyboard typematic repeats.
- Generates its own delayed auto-shift repeat for movement keys.
- Queues commands in a 4-entry FIFO drained over a valid/ready handshake.

Parameters:
- DAS_DELAY, 8000000, cycles from a fresh movement-key press to the first auto-repeat (160 ms at 50 MHz).
- ARR_PERIOD, 2500000, cycles between subsequent auto-repeats (50 ms).
- CNT_W, 24, repeat counter width; must hold max(DAS_DELAY, ARR_PERIOD).

Ports:
- clock  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous, active-low reset.
- ps2_key_pressed  in  1  one-cycle strobe; ps2_key_data is valid in that cycle.
- ps2_key_data  in  8  received scancode byte.
- flush  in  1  synchronous clear of queue, held keys, repeat engine and parser.
- cmd_ready  in  1  consumer accepts the head command.
- cmd_valid  out  1  FIFO non-empty.
- cmd_code  out  3  head command: 1 LEFT, 2 RIGHT, 3 SOFT_DROP, 4 ROT_CW, 5 HARD_DROP, 6 PAUSE, 7 ROT_CCW. Code 0 is never queued.
- held_keys  out  7  bit (code-1) set while that key is held.
- overflow  out  1  sticky; a parsed command was dropped because the FIFO was full.

Behaviour:
- Reset (async, resetn=0): cmd_valid=0, cmd_code=0, held_keys=0, overflow=0, FIFO empty, parser IDLE, repeat engine inactive, counter=0.
- Key map:
  - Extended (E0-prefixed): 6B LEFT, 74 RIGHT, 72 SOFT_DROP, 75 ROT_CW.
  - Non-extended: 29 HARD_DROP, 4D PAUSE, 1A ROT_CCW.
  - Every other code, and non-extended 6B/74/72/75, is ignored, but the parser still returns to IDLE.
- Parser FSM, advancing only on a strobe:
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is a make (ext=0) and stays in IDLE.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte is a make (ext=1) and goes to IDLE.
  - BRK: any byte is a break (ext=0) and goes to IDLE.
  - EXT_BRK: any byte is a break (ext=1) and goes to IDLE.
- Make on a mapped key:
  - Key not held: push the command and set its held bit.
  - Key already held (typematic repeat): no push, no state change.
- Break on a mapped key: clear its held bit; no push. A break of a key not held is a no-op.
- Repeat engine (LEFT, RIGHT, SOFT_DROP only; last-pressed wins):
  - A fresh make of a repeatable key sets rpt_key to that key and loads counter=DAS_DELAY-1. It replaces any active repeat.
  - While active, the counter decrements each cycle.
  - When the counter is 0, a repeat event fires: push rpt_key and reload counter=ARR_PERIOD-1.
  - A break of rpt_key deactivates the engine. It does not resume for other still-held keys.
  - A break of a non-rpt key does not affect the engine.
- Push arbitration:
  - A parser push and a repeat event in the same cycle: the parser push wins. The counter holds at 0 and the repeat event fires next cycle.
  - Repeat event with FIFO full: event silently discarded, counter reloaded, overflow unchanged.
  - Parser push with FIFO full and no pop that cycle: command dropped, overflow set. overflow clears only on reset or flush.
  - Push and pop in the same cycle while full: both are accepted.
- Latency: a strobe in cycle N producing a push makes the entry visible at cmd_valid/cmd_code in cycle N+1, when the FIFO was empty.
- Handshake: pop occurs on cmd_valid & cmd_ready. cmd_code is stable while cmd_valid=1 and not popped. Order is strictly FIFO.
- cmd_code is 0 while cmd_valid=0.
- flush=1: in the next cycle, FIFO empty, held_keys=0, engine inactive, parser IDLE, overflow=0. A strobe coinciding with flush is discarded.
- A reset mid-sequence (e.g. after E0) returns the parser to IDLE. The following byte is parsed as non-extended.

Decomposition:
- Package kbd_cmd_pkg:
  - 3-bit command code constants.
  - Scancode constants (E0, F0, 6B, 74, 72, 75, 29, 4D, 1A).
  - Parser state enum (IDLE, EXT, BRK, EXT_BRK).
  - FIFO depth constant 4.
- Sub-module cmd_fifo:
  - 4 x 3-bit storage, 2-bit read/write pointers with wrap, 3-bit count.
  - push/pop/flush inputs; full/empty outputs.
  - Same-cycle push+pop when full is legal.

Test Plan (bench overrides DAS_DELAY=20, ARR_PERIOD=5):
- Strobes E0, 6B with cmd_ready=1 -> cmd_valid=1, cmd_code=1 one cycle after the 6B strobe, popped next edge; held_keys=7'b0000001.
- Hold LEFT with no break -> first repeat LEFT visible 20 cycles after the make, then every 5 cycles; strobes E0, F0, 6B -> no further pushes, held_keys=0.
- Typematic make stream: E0 6B, E0 6B, E0 6B within 10 cycles -> exactly one LEFT queued before any auto-repeat.
- cmd_ready=0; makes for 29, 1A, 4D, E0 75, E0 72 -> 4 entries 5, 7, 6, 4 then overflow=1. SOFT_DROP push dropped. Auto-repeats while full do not affect order. Drain yields 5, 7, 6, 4.
- Break F0 29 with no prior make -> no command, held_keys unchanged. Then 29 make -> HARD_DROP queued.
- Strobe E0, then flush, then 6B -> no command (non-extended 6B ignored); overflow=0, cmd_valid=0. Assert resetn=0 with repeat active -> all outputs 0 asynchronously.
